sfp_seq: RTL

Sequencer for the special-function (accumulate + ReLU-threshold) unit. It accepts a job command (accumulation length, threshold) and runs the unit through clear, accumulate, threshold and result-hold phases. It streams operands from an upstream valid/ready source and presents a valid/ready result to the downstream consumer. It sits between the array output FIFO and one `sfp` instance; the sfp `in` data path is wired directly from upstream, and the sequencer drives only control and threshold.

---
 rtl/sfp_seq.sv | 95 +++++++++
 1 files changed

// File: rtl/sfp_seq.sv
// sfp_seq: clear / accumulate / threshold / hold sequencer for one sfp instance.
// Define SFP_SEQ_RELU_EN to include the RELU threshold phase; default build skips it.
module sfp_seq #(
    parameter int psum_bw = 16,
    parameter int len_bw  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [len_bw-1:0]  len,
    input  logic [psum_bw-1:0] thres,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               sfp_clr,
    output logic               sfp_acc,
    output logic               sfp_relu,
    output logic [psum_bw-1:0] sfp_thres,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic [len_bw-1:0]  cnt
);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        ACC,
`ifdef SFP_SEQ_RELU_EN
        RELU,
`endif
        DONE
    } state_t;

    // Phase entered once accumulation is finished (or skipped for len==0).
`ifdef SFP_SEQ_RELU_EN
    localparam state_t post_acc = RELU;
`else
    localparam state_t post_acc = DONE;
`endif

    state_t             state_q, state_d;
    logic [len_bw-1:0]  len_q;
    logic               accept_start;
    logic               last_operand;

    assign accept_start = (state_q == IDLE) && start;
    assign last_operand = (len_bw'(cnt + 1'b1) == len_q);

    // NOTE: every registered signal uses <= so all flops sample pre-edge values together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            len_q     <= '0;
            cnt       <= '0;
            sfp_thres <= '0;
        end else begin
            state_q <= state_d;
            if (accept_start) begin
                len_q     <= len;
                cnt       <= '0;
                sfp_thres <= thres;
            end else if (sfp_acc) begin
                cnt <= len_bw'(cnt + 1'b1);
            end
        end
    end

    // NOTE: state_d is defaulted before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = CLR;
            CLR:  state_d = (len_q != '0) ? ACC : post_acc;
            ACC:  if (in_valid && last_operand) state_d = post_acc;
`ifdef SFP_SEQ_RELU_EN
            RELU: state_d = DONE;
`endif
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == ACC);
    assign sfp_acc   = (state_q == ACC) && in_valid;
    // Reset also clears the datapath so the sfp accumulator never holds stale data.
    assign sfp_clr   = (state_q == CLR) || reset;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
`ifdef SFP_SEQ_RELU_EN
    assign sfp_relu  = (state_q == RELU);
`else
    assign sfp_relu  = 1'b0;
`endif

endmodule
